// File: rtl/spw_tick_pkg.sv
// Shared definitions for the SpaceWire tick capture slave: register map,
// status/mask bit positions and the time code layout.
package spw_tick_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_MASK   = 2'd2,
    ADDR_COUNT  = 2'd3
  } reg_addr_e;

  localparam int unsigned BIT_PENDING  = 0;
  localparam int unsigned BIT_OVERFLOW = 1;

  // Time code layout: [7:6] control flags, [5:0] time value
  typedef struct packed {
    logic [1:0] ctrl;
    logic [5:0] time_val;
  } timecode_t;

endpackage

// File: rtl/spw_sync_edge.sv
// Synchronizer plus rising-edge detector for a strobe, with a data bus
// delayed by the same depth so the data stays aligned with the event.
// Event and data outputs are registered.
module spw_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sig_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  evt,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic                  ts;
  logic                  td;
  logic [DATA_WIDTH-1:0] tc;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign ts = sig_in;
      assign tc = data_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [DATA_WIDTH-1:0]  dly_q [SYNC_STAGES];

      // Strobe synchronizer and matching-depth data delay line
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q <= '0;
          for (int unsigned i = 0; i < SYNC_STAGES; i++) dly_q[i] <= '0;
        end else begin
          sync_q[0] <= sig_in;
          dly_q[0]  <= data_in;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
            dly_q[i]  <= dly_q[i-1];
          end
        end
      end

      assign ts = sync_q[SYNC_STAGES-1];
      assign tc = dly_q[SYNC_STAGES-1];
    end
  endgenerate

  // Rising-edge detect on the synchronized strobe, registered with its data
  always_ff @(posedge clk) begin
    if (reset) begin
      td       <= 1'b0;
      evt      <= 1'b0;
      data_out <= '0;
    end else begin
      td       <= ts;
      evt      <= ts & ~td;
      data_out <= tc;
    end
  end

endmodule

// File: rtl/spw_tick_out_capture.sv
// Avalon-MM slave capturing SpaceWire time codes from the codec tick_out /
// time_out outputs: last code, pending/overflow flags, tick counter and a
// maskable level interrupt.
module spw_tick_out_capture
  import spw_tick_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        tick_out,
  input  logic [7:0]  time_out
);

  logic                   wr;
  logic                   tick_evt;
  timecode_t              tc;
  timecode_t              data_q;
  logic                   pending_q;
  logic                   overflow_q;
  logic [1:0]             mask_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   clr_pending;
  logic                   clr_overflow;
  reg_addr_e              addr;
  logic                   unused_wd;

  assign wr           = chipselect & ~write_n;
  assign addr         = reg_addr_e'(address);
  assign clr_pending  = wr && (addr == ADDR_STATUS) && writedata[BIT_PENDING];
  assign clr_overflow = wr && (addr == ADDR_STATUS) && writedata[BIT_OVERFLOW];
  assign unused_wd    = &{1'b0, writedata[31:2]};

  spw_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .DATA_WIDTH  (8)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (tick_out),
    .data_in  (time_out),
    .evt      (tick_evt),
    .data_out (tc)
  );

  // Register file: tick capture has priority over a same-cycle clear/write
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      mask_q     <= '0;
      count_q    <= '0;
    end else begin
      if (tick_evt) data_q <= tc;
      pending_q  <= tick_evt | (pending_q & ~clr_pending);
      overflow_q <= (tick_evt & pending_q & ~clr_pending) | (overflow_q & ~clr_overflow);
      if (wr && addr == ADDR_MASK) mask_q <= writedata[1:0];
      if (wr && addr == ADDR_COUNT)
        count_q <= tick_evt ? COUNT_WIDTH'(1) : '0;
      else if (tick_evt)
        count_q <= count_q + 1'b1;
    end
  end

  assign irq = (pending_q  & mask_q[BIT_PENDING]) |
               (overflow_q & mask_q[BIT_OVERFLOW]);

  // Read mux, ungated by chipselect, zero-extended
  always_comb begin
    readdata = '0;
    unique case (addr)
      ADDR_DATA:   readdata[7:0] = data_q;
      ADDR_STATUS: begin
        readdata[BIT_PENDING]  = pending_q;
        readdata[BIT_OVERFLOW] = overflow_q;
      end
      ADDR_MASK:   readdata[1:0] = mask_q;
      ADDR_COUNT:  readdata[COUNT_WIDTH-1:0] = count_q;
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_spw_tick_out_capture.sv
// Self-checking bench for spw_tick_out_capture: a table of directed cycles,
// hand-written corner sequences and a randomized run against a reference model.
module tb_spw_tick_out_capture;

  localparam int unsigned S  = 2;
  localparam int unsigned CW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic        tick_out = 1'b0;
  logic [7:0]  time_out = '0;

  int unsigned vecs = 0;
  int unsigned miscmp = 0;

  spw_tick_out_capture #(
    .SYNC_STAGES (S),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .tick_out   (tick_out),
    .time_out   (time_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: a tick sampled at edge k is seen at edge k+S+1 and counts
  // only if the sample before it was low.
  bit          m_h  [0:S+1];
  logic [7:0]  m_hd [0:S+1];
  logic [7:0]  m_data;
  bit          m_pend, m_ovf;
  logic [1:0]  m_mask;
  int unsigned m_count;

  function automatic void model_reset();
    for (int i = 0; i <= S + 1; i++) begin m_h[i] = 0; m_hd[i] = '0; end
    m_data = '0; m_pend = 0; m_ovf = 0; m_mask = '0; m_count = 0;
  endfunction

  function automatic void model_step();
    bit wr, evt, cl_p, cl_o, n_pend, n_ovf;
    wr = chipselect && !write_n;
    if (reset) begin
      model_reset();
      return;
    end
    evt  = m_h[S] && !m_h[S+1];
    cl_p = wr && address == 2'd1 && writedata[0];
    cl_o = wr && address == 2'd1 && writedata[1];
    n_pend = evt || (m_pend && !cl_p);
    n_ovf  = (evt && m_pend && !cl_p) || (m_ovf && !cl_o);
    m_pend = n_pend;
    m_ovf  = n_ovf;
    if (evt) m_data = m_hd[S];
    if (wr && address == 2'd2) m_mask = writedata[1:0];
    if (wr && address == 2'd3) m_count = evt ? 1 : 0;
    else if (evt) m_count = (m_count + 1) % (1 << CW);
    for (int i = S + 1; i > 0; i--) begin m_h[i] = m_h[i-1]; m_hd[i] = m_hd[i-1]; end
    m_h[0]  = tick_out;
    m_hd[0] = time_out;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, m_data};
      2'd1:    return {30'd0, m_ovf, m_pend};
      2'd2:    return {30'd0, m_mask};
      default: return m_count;
    endcase
  endfunction

  function automatic bit model_irq();
    return (m_pend && m_mask[0]) || (m_ovf && m_mask[1]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
  endtask

  task automatic tick_pulse(input logic [7:0] tc);
    tick_out = 1'b1; time_out = tc;
    step();
    tick_out = 1'b0;
    idle(4);
  endtask

  task automatic chk(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic chk_irq(input bit exp, input string name);
    #1;
    check(name, {31'd0, irq}, {31'd0, exp});
  endtask

  typedef struct {
    bit          rst;
    bit          tick;
    logic [7:0]  tc;
    bit          wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // rst tick tc wr waddr wdata raddr exp_rd exp_irq
    tbl[0]  = '{1, 0, 8'h00, 0, 2'd0, 32'h0, 2'd0, 32'h00, 0};
    tbl[1]  = '{0, 0, 8'h00, 0, 2'd0, 32'h0, 2'd1, 32'h00, 0};
    tbl[2]  = '{0, 0, 8'h00, 0, 2'd0, 32'h0, 2'd2, 32'h00, 0};
    tbl[3]  = '{0, 0, 8'h00, 0, 2'd0, 32'h0, 2'd3, 32'h00, 0};
    tbl[4]  = '{0, 1, 8'h4A, 0, 2'd0, 32'h0, 2'd1, 32'h00, 0};
    tbl[5]  = '{0, 1, 8'h4A, 0, 2'd0, 32'h0, 2'd1, 32'h00, 0};
    tbl[6]  = '{0, 1, 8'h4A, 0, 2'd0, 32'h0, 2'd3, 32'h00, 0};
    tbl[7]  = '{0, 1, 8'h4A, 0, 2'd0, 32'h0, 2'd1, 32'h01, 0};
    tbl[8]  = '{0, 1, 8'h4A, 0, 2'd0, 32'h0, 2'd0, 32'h4A, 0};
    tbl[9]  = '{0, 0, 8'h4A, 0, 2'd0, 32'h0, 2'd3, 32'h01, 0};
    tbl[10] = '{0, 0, 8'h4A, 0, 2'd0, 32'h0, 2'd3, 32'h01, 0};
    tbl[11] = '{0, 0, 8'h4A, 1, 2'd1, 32'h3, 2'd1, 32'h00, 0};
    tbl[12] = '{0, 0, 8'h4A, 1, 2'd2, 32'h1, 2'd2, 32'h01, 0};

    model_reset();
    idle(2);

    for (int i = 0; i < 13; i++) begin
      reset = tbl[i].rst; tick_out = tbl[i].tick; time_out = tbl[i].tc;
      chipselect = tbl[i].wr; write_n = !tbl[i].wr;
      address = tbl[i].waddr; writedata = tbl[i].wdata;
      step();
      reset = 1'b0;
      chk(tbl[i].raddr, tbl[i].exp_rd, $sformatf("tbl[%0d] rd", i));
      chk_irq(tbl[i].exp_irq, $sformatf("tbl[%0d] irq", i));
    end

    // Pending interrupt raised and cleared
    tick_pulse(8'h11);
    chk_irq(1, "pend irq set");
    chk(2'd1, 32'h1, "pend status");
    wr_reg(2'd1, 32'h1);
    chk_irq(0, "pend irq clr");
    chk(2'd1, 32'h0, "pend status clr");

    // Two ticks without clearing: overflow
    wr_reg(2'd3, 32'h0);
    tick_pulse(8'h05);
    tick_pulse(8'h06);
    chk(2'd0, 32'h06, "two data");
    chk(2'd1, 32'h3, "two status");
    chk(2'd3, 32'h2, "two count");
    wr_reg(2'd2, 32'h2);
    chk_irq(1, "ovf irq set");
    wr_reg(2'd1, 32'h2);
    chk(2'd1, 32'h1, "ovf clr status");
    chk_irq(0, "ovf irq clr");

    // W1C of PENDING on the tick_evt edge: no overflow
    tick_out = 1'b1; time_out = 8'h21; step();
    tick_out = 1'b0; idle(2);
    wr_reg(2'd1, 32'h1);
    chk(2'd1, 32'h1, "w1c pend + evt");
    chk(2'd3, 32'h3, "w1c pend count");

    // COUNT write on the tick_evt edge
    tick_out = 1'b1; time_out = 8'h22; step();
    tick_out = 1'b0; idle(2);
    wr_reg(2'd3, 32'hDEAD);
    chk(2'd3, 32'h1, "count wr + evt");
    chk(2'd1, 32'h3, "count wr status");

    // W1C of OVERFLOW on an edge that sets it
    tick_out = 1'b1; time_out = 8'h23; step();
    tick_out = 1'b0; idle(2);
    wr_reg(2'd1, 32'h2);
    chk(2'd1, 32'h3, "w1c ovf + evt");
    chk(2'd0, 32'h23, "w1c ovf data");

    // Counter wrap and read-only DATA
    wr_reg(2'd3, 32'h0);
    for (int i = 0; i < 17; i++) tick_pulse(8'(i));
    chk(2'd3, 32'h1, "count wrap");
    wr_reg(2'd0, 32'hFF);
    chk(2'd0, 32'h10, "data ro");

    // Reset while a tick is in the sync chain
    tick_out = 1'b1; time_out = 8'h77; step();
    reset = 1'b1; step();
    reset = 1'b0; tick_out = 1'b0; idle(6);
    chk(2'd3, 32'h0, "rst inflight count");
    chk(2'd1, 32'h0, "rst inflight status");
    chk(2'd0, 32'h0, "rst inflight data");

    // Randomized run against the reference model
    begin
      int hold = 0;
      for (int c = 0; c < 400; c++) begin
        if (tick_out && hold > 0) hold--;
        else begin
          tick_out = ($urandom_range(0, 3) == 0);
          hold = $urandom_range(0, 3);
          if (!tick_out) time_out = 8'($urandom);
        end
        reset = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 3) == 0) begin
          chipselect = 1'b1; write_n = 1'b0;
          address = 2'($urandom); writedata = $urandom;
        end else begin
          chipselect = $urandom_range(0, 1); write_n = 1'b1;
        end
        step();
        reset = 1'b0;
        for (int a = 0; a < 4; a++)
          chk(2'(a), model_rd(2'(a)), $sformatf("rand c%0d a%0d", c, a));
        chk_irq(model_irq(), $sformatf("rand c%0d irq", c));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
